// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage MIPS pipeline: ID-stage decode, load-use and
// branch hazard handling, and the control bundle carried through ID/EX, EX/MEM and MEM/WB.
module pipe_ctrl_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned EXT_ISA = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [5:0]         id_op,
    input  logic [5:0]         id_funct,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_br_taken,
    output logic               stall,
    output logic               flush_if,
    output logic [1:0]         id_s_npc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_s_b,
    output logic               ex_s_ext,
    output logic               ex_is_branch,
    output logic               ex_br_ne,
    output logic               ex_illegal,
    output logic               mem_write,
    output logic               mem_read,
    output logic               wb_reg_write,
    output logic [1:0]         wb_s_data_write,
    output logic [REG_AW-1:0]  wb_waddr
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnJalr  = 6'b001001;
    localparam logic [5:0] FnSlt   = 6'b101010;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbPc8 = 2'd2;

    localparam logic [1:0] NpcSeq = 2'd0;
    localparam logic [1:0] NpcJmp = 2'd1;
    localparam logic [1:0] NpcReg = 2'd2;

    localparam bit ExtOn = (EXT_ISA != 0);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               s_b;
        logic               s_ext;
        logic               is_branch;
        logic               br_ne;
        logic               illegal;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic [1:0]         s_data_write;
        logic [REG_AW-1:0]  waddr;
    } ex_bundle_t;

    typedef struct packed {
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic [1:0]         s_data_write;
        logic [REG_AW-1:0]  waddr;
    } mem_bundle_t;

    typedef struct packed {
        logic               reg_write;
        logic [1:0]         s_data_write;
        logic [REG_AW-1:0]  waddr;
    } wb_bundle_t;

    ex_bundle_t  dec;
    logic [1:0]  dec_npc;
    logic        legal;
    logic        uses_rt;
    logic        load_use;
    logic        br_flush;
    ex_bundle_t  idex_d, idex_q;
    mem_bundle_t exmem_d, exmem_q;
    wb_bundle_t  memwb_d, memwb_q;

    // ID-stage decode
    always_comb begin
        dec     = '0;
        dec_npc = NpcSeq;
        legal   = 1'b1;
        uses_rt = 1'b0;
        unique case (id_op)
            OpRtype: begin
                uses_rt = 1'b1;
                if (id_funct == FnJr) begin
                    dec_npc = NpcReg;
                end else if (id_funct == FnJalr) begin
                    if (ExtOn) begin
                        dec_npc            = NpcReg;
                        dec.waddr          = id_rd;
                        dec.reg_write      = 1'b1;
                        dec.s_data_write   = WbPc8;
                    end else begin
                        legal = 1'b0;
                    end
                end else if (id_funct == FnSlt && !ExtOn) begin
                    legal = 1'b0;
                end else begin
                    dec.aluop     = ALUOP_W'(id_funct[3:0]);
                    dec.s_b       = 1'b1;
                    dec.waddr     = id_rd;
                    dec.reg_write = 1'b1;
                end
            end
            OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLui, OpLw: begin
                dec.waddr     = id_rt;
                dec.reg_write = 1'b1;
                unique case (id_op)
                    OpAddi:  begin dec.aluop = ALUOP_W'(4'b0000); dec.s_ext = 1'b1; end
                    OpAddiu: begin dec.aluop = ALUOP_W'(4'b0001); dec.s_ext = 1'b1; end
                    OpSlti:  begin
                        dec.aluop = ALUOP_W'(4'b1010);
                        dec.s_ext = 1'b1;
                        legal     = ExtOn;
                    end
                    OpAndi:  dec.aluop = ALUOP_W'(4'b0100);
                    OpOri:   dec.aluop = ALUOP_W'(4'b0101);
                    OpLui:   dec.aluop = ALUOP_W'(4'b1111);
                    default: begin
                        dec.aluop        = ALUOP_W'(4'b0001);
                        dec.s_ext        = 1'b1;
                        dec.mem_read     = 1'b1;
                        dec.s_data_write = WbMem;
                    end
                endcase
            end
            OpSw: begin
                uses_rt       = 1'b1;
                dec.aluop     = ALUOP_W'(4'b0001);
                dec.s_ext     = 1'b1;
                dec.mem_write = 1'b1;
            end
            OpBeq, OpBne: begin
                uses_rt       = 1'b1;
                dec.aluop     = ALUOP_W'(4'b0011);
                dec.s_b       = 1'b1;
                dec.is_branch = 1'b1;
                dec.br_ne     = (id_op == OpBne);
                if (id_op == OpBne && !ExtOn) legal = 1'b0;
            end
            OpJ: dec_npc = NpcJmp;
            OpJal: begin
                dec_npc          = NpcJmp;
                dec.waddr        = REG_AW'(31);
                dec.reg_write    = 1'b1;
                dec.s_data_write = WbPc8;
            end
            default: legal = 1'b0;
        endcase

        if (!legal || !id_valid) begin
            dec         = '0;
            dec.illegal = id_valid;
            dec_npc     = NpcSeq;
        end
        // $0 is hardwired; never let it look like a real destination.
        if (dec.waddr == '0) dec.reg_write = 1'b0;
    end

    // Hazard and redirect control
    always_comb begin
        load_use = idex_q.mem_read && (idex_q.waddr != '0) && id_valid &&
                   ((idex_q.waddr == id_rs) || (uses_rt && idex_q.waddr == id_rt));
        br_flush = idex_q.is_branch & (ex_br_taken ^ idex_q.br_ne);
        stall    = load_use & ~br_flush;
        id_s_npc = (load_use || br_flush) ? NpcSeq : dec_npc;
        flush_if = br_flush | ((dec_npc != NpcSeq) & ~load_use);
        if (!reset) begin
            stall    = 1'b0;
            flush_if = 1'b0;
            id_s_npc = NpcSeq;
        end
    end

    always_comb begin
        idex_d = (load_use || br_flush) ? '0 : dec;

        exmem_d              = '0;
        exmem_d.mem_write    = idex_q.mem_write;
        exmem_d.mem_read     = idex_q.mem_read;
        exmem_d.reg_write    = idex_q.reg_write;
        exmem_d.s_data_write = idex_q.s_data_write;
        exmem_d.waddr        = idex_q.waddr;

        memwb_d              = '0;
        memwb_d.reg_write    = exmem_q.reg_write;
        memwb_d.s_data_write = exmem_q.s_data_write;
        memwb_d.waddr        = exmem_q.waddr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_aluop        = idex_q.aluop;
    assign ex_s_b          = idex_q.s_b;
    assign ex_s_ext        = idex_q.s_ext;
    assign ex_is_branch    = idex_q.is_branch;
    assign ex_br_ne        = idex_q.br_ne;
    assign ex_illegal      = idex_q.illegal;
    assign mem_write       = exmem_q.mem_write;
    assign mem_read        = exmem_q.mem_read;
    assign wb_reg_write    = memwb_q.reg_write;
    assign wb_s_data_write = memwb_q.s_data_write;
    assign wb_waddr        = memwb_q.waddr;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with the extended ISA, one without.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_op, id_funct;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_br_taken;

    logic       stall, flush_if, ex_s_b, ex_s_ext, ex_is_branch, ex_br_ne, ex_illegal;
    logic       mem_write, mem_read, wb_reg_write;
    logic [1:0] id_s_npc, wb_s_data_write;
    logic [3:0] ex_aluop;
    logic [4:0] wb_waddr;

    logic       stall0, flush_if0, ex_s_b0, ex_s_ext0, ex_is_branch0, ex_br_ne0, ex_illegal0;
    logic       mem_write0, mem_read0, wb_reg_write0;
    logic [1:0] id_s_npc0, wb_s_data_write0;
    logic [3:0] ex_aluop0;
    logic [4:0] wb_waddr0;

    logic [22:0] all_out, all_out0;
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_JR = 6'b001000, FN_JALR = 6'b001001;

    always #5 clk = ~clk;

    assign all_out = {stall, flush_if, id_s_npc, ex_aluop, ex_s_b, ex_s_ext, ex_is_branch,
                      ex_br_ne, ex_illegal, mem_write, mem_read, wb_reg_write,
                      wb_s_data_write, wb_waddr};
    assign all_out0 = {stall0, flush_if0, id_s_npc0, ex_aluop0, ex_s_b0, ex_s_ext0,
                       ex_is_branch0, ex_br_ne0, ex_illegal0, mem_write0, mem_read0,
                       wb_reg_write0, wb_s_data_write0, wb_waddr0};

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .EXT_ISA(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
        .stall(stall), .flush_if(flush_if), .id_s_npc(id_s_npc), .ex_aluop(ex_aluop),
        .ex_s_b(ex_s_b), .ex_s_ext(ex_s_ext), .ex_is_branch(ex_is_branch),
        .ex_br_ne(ex_br_ne), .ex_illegal(ex_illegal), .mem_write(mem_write),
        .mem_read(mem_read), .wb_reg_write(wb_reg_write),
        .wb_s_data_write(wb_s_data_write), .wb_waddr(wb_waddr)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .EXT_ISA(0)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
        .stall(stall0), .flush_if(flush_if0), .id_s_npc(id_s_npc0), .ex_aluop(ex_aluop0),
        .ex_s_b(ex_s_b0), .ex_s_ext(ex_s_ext0), .ex_is_branch(ex_is_branch0),
        .ex_br_ne(ex_br_ne0), .ex_illegal(ex_illegal0), .mem_write(mem_write0),
        .mem_read(mem_read0), .wb_reg_write(wb_reg_write0),
        .wb_s_data_write(wb_s_data_write0), .wb_waddr(wb_waddr0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if (all_out !== 23'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        n_checks++;
        if (all_out0 !== 23'd0) begin
            n_errors++; $display("FAIL reset_outputs_noext: got %h want 0", all_out0);
        end
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        drive(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd8, 5'd0);
        tick();
        n_checks++;
        if ({ex_aluop, ex_s_b, ex_s_ext} !== {4'b0000, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL addi_ex: got %b want 000001", {ex_aluop, ex_s_b, ex_s_ext});
        end
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        n_checks++;
        if ({wb_reg_write, wb_waddr, wb_s_data_write} !== {1'b1, 5'd8, 2'd0}) begin
            n_errors++; $display("FAIL addi_wb: got %b want 1_01000_00",
                                 {wb_reg_write, wb_waddr, wb_s_data_write});
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, OP_LW, 6'd0, 5'd0, 5'd9, 5'd0);
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_pre_stall: got %b want 0", stall); end
        tick();
        drive(1'b1, OP_R, FN_ADDU, 5'd9, 5'd9, 5'd10);
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        n_checks++;
        if ({ex_aluop, ex_s_b, mem_read} !== {4'b0000, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL lu_bubble: got %b want 000001", {ex_aluop, ex_s_b, mem_read});
        end
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_one_cycle: got %b want 0", stall); end
        tick();
        n_checks++;
        if ({ex_aluop, ex_s_b} !== {4'b0001, 1'b1}) begin
            n_errors++; $display("FAIL lu_late_addu: got %b want 00011", {ex_aluop, ex_s_b});
        end
        // Load into $0 never stalls
        drive(1'b1, OP_LW, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_R, FN_ADDU, 5'd0, 5'd0, 5'd10);
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_zero_reg: got %b want 0", stall); end
        tick();
        // I-type rt is a destination, not a source
        drive(1'b1, OP_LW, 6'd0, 5'd0, 5'd9, 5'd0);
        tick();
        drive(1'b1, OP_ADDI, 6'd0, 5'd1, 5'd9, 5'd0);
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_itype_rt: got %b want 0", stall); end
        drive(1'b1, OP_SW, 6'd0, 5'd1, 5'd9, 5'd0);
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL lu_sw_rt: got %b want 1", stall); end
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_branch();
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        n_checks++;
        if ({ex_is_branch, ex_br_ne, ex_aluop, ex_s_b} !== {1'b1, 1'b0, 4'b0011, 1'b1}) begin
            n_errors++; $display("FAIL beq_ex: got %b want 1000111",
                                 {ex_is_branch, ex_br_ne, ex_aluop, ex_s_b});
        end
        ex_br_taken = 1'b1;
        drive(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd3, 5'd0);
        n_checks++;
        if ({flush_if, stall} !== 2'b10) begin
            n_errors++; $display("FAIL beq_taken_flush: got %b want 10", {flush_if, stall});
        end
        tick();
        ex_br_taken = 1'b0;
        #1;
        n_checks++;
        if ({ex_is_branch, ex_s_ext, flush_if} !== 3'b000) begin
            n_errors++; $display("FAIL beq_bubble: got %b want 000", {ex_is_branch, ex_s_ext, flush_if});
        end
        // BNE not-taken comparator output means the branch is taken
        drive(1'b1, OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd3, 5'd0);
        n_checks++;
        if ({ex_br_ne, flush_if} !== 2'b11) begin
            n_errors++; $display("FAIL bne_flush: got %b want 11", {ex_br_ne, flush_if});
        end
        tick();
        n_checks++;
        if (ex_s_ext !== 1'b0) begin n_errors++; $display("FAIL bne_bubble: got %b want 0", ex_s_ext); end
        // BEQ not taken: instruction behind it proceeds
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd3, 5'd0);
        n_checks++;
        if (flush_if !== 1'b0) begin n_errors++; $display("FAIL beq_nt_flush: got %b want 0", flush_if); end
        tick();
        n_checks++;
        if (ex_s_ext !== 1'b1) begin n_errors++; $display("FAIL beq_nt_pass: got %b want 1", ex_s_ext); end
        // Taken branch suppresses a jump sitting in ID
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        ex_br_taken = 1'b1;
        drive(1'b1, OP_J, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if ({id_s_npc, flush_if} !== 3'b001) begin
            n_errors++; $display("FAIL br_over_jump: got %b want 001", {id_s_npc, flush_if});
        end
        tick();
        ex_br_taken = 1'b0;
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_jal_jr();
        drive(1'b1, OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0);
        n_checks++;
        if ({id_s_npc, flush_if} !== 3'b011) begin
            n_errors++; $display("FAIL jal_npc: got %b want 011", {id_s_npc, flush_if});
        end
        tick();
        drive(1'b1, OP_R, FN_JR, 5'd31, 5'd0, 5'd0);
        n_checks++;
        if ({id_s_npc, flush_if, stall} !== 4'b1010) begin
            n_errors++; $display("FAIL jr_npc: got %b want 1010", {id_s_npc, flush_if, stall});
        end
        tick();
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++;
        if ({wb_reg_write, wb_waddr, wb_s_data_write} !== {1'b1, 5'd31, 2'd2}) begin
            n_errors++; $display("FAIL jal_wb: got %b want 1_11111_10",
                                 {wb_reg_write, wb_waddr, wb_s_data_write});
        end
        tick();
        n_checks++;
        if (wb_reg_write !== 1'b0) begin n_errors++; $display("FAIL jr_nowrite: got %b want 0", wb_reg_write); end
        // Jump held back while stalled on its source register
        drive(1'b1, OP_LW, 6'd0, 5'd0, 5'd9, 5'd0);
        tick();
        drive(1'b1, OP_R, FN_JALR, 5'd9, 5'd0, 5'd4);
        n_checks++;
        if ({stall, id_s_npc, flush_if} !== 4'b1000) begin
            n_errors++; $display("FAIL jalr_stalled: got %b want 1000", {stall, id_s_npc, flush_if});
        end
        tick();
        n_checks++;
        if ({stall, id_s_npc, flush_if} !== 4'b0101) begin
            n_errors++; $display("FAIL jalr_released: got %b want 0101", {stall, id_s_npc, flush_if});
        end
        n_checks++;
        if ({id_s_npc0, flush_if0} !== 3'b000) begin
            n_errors++; $display("FAIL jalr_noext: got %b want 000", {id_s_npc0, flush_if0});
        end
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_ext_isa();
        drive(1'b1, OP_SLTI, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        n_checks++;
        if ({ex_aluop, ex_illegal} !== {4'b1010, 1'b0}) begin
            n_errors++; $display("FAIL slti_ext: got %b want 10100", {ex_aluop, ex_illegal});
        end
        n_checks++;
        if ({ex_aluop0, ex_illegal0} !== {4'b0000, 1'b1}) begin
            n_errors++; $display("FAIL slti_noext: got %b want 00001", {ex_aluop0, ex_illegal0});
        end
        drive(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++;
        if (ex_illegal !== 1'b1) begin n_errors++; $display("FAIL bad_op_illegal: got %b want 1", ex_illegal); end
        n_checks++;
        if ({mem_write0, mem_read0} !== 2'b00) begin
            n_errors++; $display("FAIL slti_noext_mem: got %b want 00", {mem_write0, mem_read0});
        end
        drive(1'b0, 6'b111111, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++;
        if (ex_illegal !== 1'b0) begin n_errors++; $display("FAIL invalid_not_illegal: got %b want 0", ex_illegal); end
        n_checks++;
        if (wb_reg_write0 !== 1'b0) begin
            n_errors++; $display("FAIL slti_noext_wb: got %b want 0", wb_reg_write0);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_SW, 6'd0, 5'd0, 5'd4, 5'd0);
        tick();
        drive(1'b1, OP_LW, 6'd0, 5'd0, 5'd9, 5'd0);
        tick();
        drive(1'b1, OP_R, FN_ADDU, 5'd9, 5'd1, 5'd10);
        n_checks++;
        if ({stall, mem_write, ex_aluop} !== {1'b1, 1'b1, 4'b0001}) begin
            n_errors++; $display("FAIL pre_reset_state: got %b want 110001", {stall, mem_write, ex_aluop});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (all_out !== 23'd0) begin
            n_errors++; $display("FAIL async_reset: got %h want 0", all_out);
        end
        drive(1'b1, OP_ADDI, 6'd0, 5'd0, 5'd8, 5'd0);
        reset = 1'b1;
        tick();
        n_checks++;
        if ({ex_s_ext, mem_write, mem_read, wb_reg_write} !== 4'b1000) begin
            n_errors++; $display("FAIL post_reset_1: got %b want 1000",
                                 {ex_s_ext, mem_write, mem_read, wb_reg_write});
        end
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_checks++;
        if ({mem_write, wb_reg_write} !== 2'b00) begin
            n_errors++; $display("FAIL post_reset_2: got %b want 00", {mem_write, wb_reg_write});
        end
        tick();
        n_checks++;
        if ({wb_reg_write, wb_waddr} !== {1'b1, 5'd8}) begin
            n_errors++; $display("FAIL post_reset_wb: got %b want 101000", {wb_reg_write, wb_waddr});
        end
    endtask

    initial begin
        reset = 1'b0;
        ex_br_taken = 1'b0;
        id_valid = 1'b0; id_op = '0; id_funct = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        #12;
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_ext_isa();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Second-generation control unit for the 5-stage MIPS pipeline.
- Decodes the ID-stage instruction into a control bundle, then carries that bundle through its own ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and generates stall and flush signals.
- Resolves jumps in ID and branches in EX; optionally decodes an extended ISA subset.

Parameters:
- REG_AW, 5: register-address width.
- ALUOP_W, 4: aluop width; must be at least 4.
- EXT_ISA, 1: when 1, BNE, SLT, SLTI and JALR are decoded; when 0 they are illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_op  in  6  opcode
- id_funct  in  6  funct field
- id_rs  in  REG_AW  rs field
- id_rt  in  REG_AW  rt field
- id_rd  in  REG_AW  rd field
- ex_br_taken  in  1  branch condition from EX comparator; meaningful only when ex_is_branch=1
- stall  out  1  freeze PC and IF/ID this cycle
- flush_if  out  1  turn IF/ID into a bubble at the next edge
- id_s_npc  out  2  next-PC select for ID jumps: 0=PC+4, 1=J target, 2=JR/JALR register
- ex_aluop  out  ALUOP_W  ALU operation
- ex_s_b  out  1  ALU B select: 1=register, 0=immediate
- ex_s_ext  out  1  1=sign-extend, 0=zero-extend
- ex_is_branch  out  1  EX holds BEQ or BNE
- ex_br_ne  out  1  1=BNE
- ex_illegal  out  1  EX holds an undecodable instruction
- mem_write  out  1  data-memory write enable
- mem_read  out  1  load in MEM
- wb_reg_write  out  1  register-file write enable
- wb_s_data_write  out  2  write-back source: 0=ALU, 1=MEM, 2=PC+8
- wb_waddr  out  REG_AW  destination register

Behaviour:

Decode (combinational, ID stage):
- R-type with funct other than JR/JALR: aluop=funct[3:0], dest=rd, s_b=1, reg_write=1.
- ADDI: aluop 0000, sign-extend.
- ADDIU, LW, SW: aluop 0001, sign-extend.
- ANDI: aluop 0100, zero-extend. ORI: aluop 0101, zero-extend.
- LUI: aluop 1111. SLTI (EXT_ISA only): aluop 1010, sign-extend.
- All I-type ALU ops: s_b=0, dest=rt.
- LW: mem_read=1, wb source 1.
- SW: mem_write=1, reg_write=0.
- BEQ / BNE: aluop 0011, s_b=1, is_branch=1, no write.
- J: id_s_npc=1.
- JAL: id_s_npc=1, dest=31, wb source 2.
- JR: id_s_npc=2. JALR: id_s_npc=2, dest=rd, wb source 2.
- If id_valid=0, any other opcode/funct, or an EXT op with EXT_ISA=0: decode to a bubble (all enables 0, id_s_npc=0). Illegal decode with id_valid=1 also sets illegal=1.
- reg_write is forced to 0 whenever dest==0.

Hazard detection (combinational):
- Load-use condition: mem_read in the ID/EX register AND ID/EX dest != 0 AND id_valid AND dest matches id_rs or id_rt.
- id_rt is compared only for R-type, branches, SW and JR/JALR.
- Load-use asserts stall=1 and inserts a bubble into ID/EX at the next edge.

Flush:
- ex_is_branch & (ex_br_taken XOR ex_br_ne): flush_if=1 and a bubble into ID/EX at the next edge. This overrides stall (stall=0) and suppresses id_s_npc (forced 0).
- ID jump, not stalled and not branch-flushed: flush_if=1; the jump proceeds down the pipe.
- A jump in ID while stalled: id_s_npc=0 until the stall clears.

Pipeline registers:
- ID/EX loads the decoded bundle each cycle, or a bubble on stall/flush.
- EX/MEM and MEM/WB shift unconditionally.
- Latency: decode in cycle N, visible on ex_* in N+1, mem_* in N+2, wb_* in N+3.

Reset:
- Reset low clears all three stage registers to a bubble, asynchronously.
- All outputs read 0 during reset, including wb_waddr=0 and stall=0.
- Reset mid-stall drops the stall immediately.
- The first post-reset edge decodes normally.

Test Plan:
- ADDI $8,$0,5 with id_valid=1:
  - cycle+1: ex_aluop=0000, ex_s_b=0, ex_s_ext=1.
  - cycle+3: wb_reg_write=1, wb_waddr=8, wb_s_data_write=0.
- LW $9 followed by ADDU $10,$9,$9:
  - stall=1 for exactly one cycle; ex_* shows a bubble.
  - ADDU reaches EX one cycle late.
  - LW into $0 followed by a use of $0: no stall.
- BEQ with ex_br_taken=1, and BNE with ex_br_taken=0:
  - flush_if=1 for one cycle; next ex_* is a bubble.
  - Same cycle as a load-use condition: stall=0.
  - BEQ with ex_br_taken=0: no flush.
- JAL then JR $31:
  - JAL: id_s_npc=1, flush_if=1; three cycles later wb_waddr=31, wb_s_data_write=2.
  - JR: id_s_npc=2, no register write.
- EXT_ISA=0 bench, SLTI with id_valid=1:
  - ex_illegal=1 next cycle.
  - No mem_write or wb_reg_write ever results.
  - EXT_ISA=1: SLTI gives ex_aluop=1010.
- Reset pulsed low mid-stream with LW in EX and SW in MEM:
  - All outputs 0 asynchronously.
  - No writes from the killed instructions after release.
